// File: rtl/cache_req_pkg.sv
// Shared types and constants for the cache request arbiter: field widths,
// the fixed low bits of every packed request, and the slot FSM states.
package cache_req_pkg;

  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 4;
  localparam int FIXED_W  = 94;
  localparam int FLAT_W   = INDEX_W + OFFSET_W + FIXED_W;

  localparam logic [FIXED_W-1:0] CACHE_REQ_FIXED = 94'h277bad0badf00d0000000080;

  typedef struct packed {
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [FIXED_W-1:0]  fixed;
  } cache_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  function automatic cache_req_t pack_req(input logic [INDEX_W-1:0]  idx,
                                          input logic [OFFSET_W-1:0] off);
    cache_req_t r;
    r.index  = idx;
    r.offset = off;
    r.fixed  = CACHE_REQ_FIXED;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: the first set bit of req at or after start,
// wrapping NUM_REQ-1 -> 0, as a one-hot grant plus its binary id.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  always_comb begin
    // Rotate so that bit 0 is the requester at start; start is always < NUM_REQ.
    rot = NUM_REQ'({req, req} >> start);
    off = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = ID_W'(i);
        any = 1'b1;
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (ID_W+1)'(NUM_REQ)) begin
      sum = sum - (ID_W+1)'(NUM_REQ);
    end
    grant_id = sum[ID_W-1:0];
    grant    = any ? (NUM_REQ'(1) << grant_id) : '0;
  end

endmodule

// File: rtl/cache_request_arbiter.sv
// Round-robin arbiter feeding one registered packed cache request slot.
// Define CACHE_ARB_BURST_EN to let a requester keep winning for up to BURST_LEN grants.
module cache_request_arbiter
  import cache_req_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
`ifdef CACHE_ARB_BURST_EN
  ,
  parameter int BURST_LEN = 4
`endif
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*INDEX_W-1:0]  req_index,
  input  logic [NUM_REQ*OFFSET_W-1:0] req_offset,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FLAT_W-1:0]           out_request,
  output logic [ID_W-1:0]             out_id
);

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  cache_req_t         out_request_q, out_request_d;

  logic               slot_free;
  logic               do_grant;
  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_id;
  logic               grant_any;
  logic [ID_W-1:0]    grant_next_ptr;
  logic               burst_hold;

  logic [INDEX_W-1:0]  idx_term [NUM_REQ];
  logic [OFFSET_W-1:0] off_term [NUM_REQ];
  logic [INDEX_W-1:0]  sel_index;
  logic [OFFSET_W-1:0] sel_offset;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req      (req_valid),
    .start    (rr_ptr_q),
    .grant    (pick_grant),
    .grant_id (pick_id),
    .any      (pick_any)
  );

  // The slot can take a new request when empty, or when it drains this cycle.
  assign slot_free = (state_q == IDLE) || out_ready;

`ifdef CACHE_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  assign burst_hold = (state_q == FULL) && req_valid[out_id_q] &&
                      (burst_cnt_q < CNT_W'(BURST_LEN - 1));

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (do_grant) begin
      burst_cnt_d = burst_hold ? burst_cnt_q + CNT_W'(1) : '0;
    end else if (state_d == IDLE) begin
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_hold = 1'b0;
`endif

  always_comb begin
    grant_oh  = pick_grant;
    grant_id  = pick_id;
    grant_any = pick_any;
    if (burst_hold) begin
      grant_oh  = NUM_REQ'(1) << out_id_q;
      grant_id  = out_id_q;
      grant_any = 1'b1;
    end
  end

  assign do_grant       = slot_free && grant_any;
  assign grant_next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_term
      assign idx_term[gi] = grant_oh[gi] ? req_index[INDEX_W*gi +: INDEX_W] : '0;
      assign off_term[gi] = grant_oh[gi] ? req_offset[OFFSET_W*gi +: OFFSET_W] : '0;
    end
  endgenerate

  always_comb begin
    sel_index  = '0;
    sel_offset = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_index  = sel_index | idx_term[i];
      sel_offset = sel_offset | off_term[i];
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_grant) state_d = FULL;
      FULL:    if (out_ready && !do_grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = (reset_n && do_grant) ? grant_oh : '0;
    out_valid = (state_q == FULL);
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    out_id_d      = out_id_q;
    out_request_d = out_request_q;
    if (do_grant) begin
      rr_ptr_d      = burst_hold ? rr_ptr_q : grant_next_ptr;
      out_id_d      = grant_id;
      out_request_d = pack_req(sel_index, sel_offset);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= '0;
      out_id_q      <= '0;
      out_request_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      out_id_q      <= out_id_d;
      out_request_q <= out_request_d;
    end
  end

  assign out_request = out_request_q;
  assign out_id      = out_id_q;

endmodule
